// File: rtl/adc_serial_arbiter.sv
// adc_serial_arbiter
// Shares the ADC 3-wire serial register port between three requesters
// (0: power/cal sequencer, 1: host UART write, 2: run-time trim) and shifts
// the granted {FRAME_HDR, addr, data} word out MSB first on Sclk/Sdata/Select.
// Frame: SETUP (SCLK_DIV) + 32 bits x (2*SCLK_DIV) + HOLD (SCLK_DIV) with
// Select low, then GAP_CYCLES of Select high before the next grant.
// Build option: define ADC_SER_RR_EN for round-robin arbitration; when it is
// undefined the arbiter uses fixed priority 0 > 1 > 2.
module adc_serial_arbiter #(
  parameter int          SCLK_DIV   = 4,
  parameter int          GAP_CYCLES = 16,
  parameter logic [11:0] FRAME_HDR  = 12'h001
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [2:0]  i_req,
  input  logic [3:0]  i_addr0,
  input  logic [3:0]  i_addr1,
  input  logic [3:0]  i_addr2,
  input  logic [15:0] i_data0,
  input  logic [15:0] i_data1,
  input  logic [15:0] i_data2,
  output logic [2:0]  o_grant,
  output logic [2:0]  o_done,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_sclk,
  output logic        o_sdata,
  output logic        o_select
);

  // One counter serves both the Sclk half-periods and the inter-frame gap.
  localparam int CNT_MAX = (SCLK_DIV > GAP_CYCLES) ? SCLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [4:0]        r_bit;
  logic [4:0]        w_bit_nxt;
  logic [31:0]       r_shift;
  logic [31:0]       w_shift_nxt;
  logic [2:0]        r_grant;
  logic [2:0]        w_grant_nxt;
  logic [2:0]        r_done;
  logic [2:0]        w_done_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_sclk;
  logic              w_sclk_nxt;
  logic              r_sdata;
  logic              w_sdata_nxt;
  logic              r_select;
  logic              w_select_nxt;
  logic              w_active;

  logic [1:0]        w_pick;
  logic [2:0]        w_pick_onehot;
  logic [3:0]        w_addr;
  logic [15:0]       w_data;

`ifdef ADC_SER_RR_EN
  logic [1:0]        r_last;
  logic [1:0]        w_last_nxt;

  // Round-robin: search starts just after the last granted index.
  function automatic logic [1:0] pick_rr(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    case (last)
      2'd0:    idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
    return idx;
  endfunction
`else
  // Fixed priority: requester 0 beats 1 beats 2.
  function automatic logic [1:0] pick_fixed(input logic [2:0] req);
    logic [1:0] idx;
    if (req[0]) begin
      idx = 2'd0;
    end else if (req[1]) begin
      idx = 2'd1;
    end else begin
      idx = 2'd2;
    end
    return idx;
  endfunction
`endif

  // Choose the winning requester and route its address/data to the loader
  always_comb begin
`ifdef ADC_SER_RR_EN
    w_pick = pick_rr(i_req, r_last);
`else
    w_pick = pick_fixed(i_req);
`endif
    case (w_pick)
      2'd0: begin
        w_addr        = i_addr0;
        w_data        = i_data0;
        w_pick_onehot = 3'b001;
      end
      2'd1: begin
        w_addr        = i_addr1;
        w_data        = i_data1;
        w_pick_onehot = 3'b010;
      end
      default: begin
        w_addr        = i_addr2;
        w_data        = i_data2;
        w_pick_onehot = 3'b100;
      end
    endcase
  end

  assign w_active = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_grant_nxt  = r_grant;
    w_done_nxt   = 3'b000;
    w_err_nxt    = 1'b0;
    w_busy_nxt   = r_busy;
    w_sclk_nxt   = r_sclk;
    w_sdata_nxt  = r_sdata;
    w_select_nxt = r_select;
`ifdef ADC_SER_RR_EN
    w_last_nxt   = r_last;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_enable && (i_req != 3'b000)) begin
          w_state_nxt  = ST_SETUP;
          w_cnt_nxt    = '0;
          w_bit_nxt    = 5'd0;
          w_shift_nxt  = {FRAME_HDR, w_addr, w_data};
          w_grant_nxt  = w_pick_onehot;
          w_busy_nxt   = 1'b1;
          w_select_nxt = 1'b0;
          w_sclk_nxt   = 1'b0;
          w_sdata_nxt  = FRAME_HDR[11];
`ifdef ADC_SER_RR_EN
          w_last_nxt   = w_pick;
`endif
        end else begin
          w_busy_nxt   = 1'b0;
        end
      end
      ST_SETUP: begin
        if (r_cnt == DIV_LAST) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
          w_sclk_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt != DIV_LAST) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end else if (r_sclk) begin
          // Falling edge: present the next bit so it is stable for the next rise.
          w_cnt_nxt   = '0;
          w_sclk_nxt  = 1'b0;
          w_shift_nxt = {r_shift[30:0], 1'b0};
          w_sdata_nxt = r_shift[30];
        end else if (r_bit == 5'd31) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = '0;
          w_sclk_nxt  = 1'b1;
          w_bit_nxt   = r_bit + 5'd1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == DIV_LAST) begin
          w_state_nxt  = ST_GAP;
          w_cnt_nxt    = '0;
          w_select_nxt = 1'b1;
          w_sdata_nxt  = 1'b0;
          w_done_nxt   = r_grant;
          w_grant_nxt  = 3'b000;
        end else begin
          w_cnt_nxt    = r_cnt + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = '0;
        w_grant_nxt  = 3'b000;
        w_busy_nxt   = 1'b0;
        w_sclk_nxt   = 1'b0;
        w_sdata_nxt  = 1'b0;
        w_select_nxt = 1'b1;
      end
    endcase

    // Losing the ADC supply mid-frame releases the port and reports an error.
    if (w_active && !i_enable) begin
      w_state_nxt  = ST_GAP;
      w_cnt_nxt    = '0;
      w_select_nxt = 1'b1;
      w_sclk_nxt   = 1'b0;
      w_sdata_nxt  = 1'b0;
      w_grant_nxt  = 3'b000;
      w_done_nxt   = 3'b000;
      w_err_nxt    = 1'b1;
    end else begin
      w_err_nxt    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered port outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_bit    <= 5'd0;
      r_shift  <= 32'h0000_0000;
      r_grant  <= 3'b000;
      r_done   <= 3'b000;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_sclk   <= 1'b0;
      r_sdata  <= 1'b0;
      r_select <= 1'b1;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= w_busy_nxt;
      r_sclk   <= w_sclk_nxt;
      r_sdata  <= w_sdata_nxt;
      r_select <= w_select_nxt;
    end
  end

`ifdef ADC_SER_RR_EN
  // Last granted index for the round-robin search; starts at 2 so 0 is tried first
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 2'd2;
    end else begin
      r_last <= w_last_nxt;
    end
  end
`endif

  assign o_grant  = r_grant;
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_busy   = r_busy;
  assign o_sclk   = r_sclk;
  assign o_sdata  = r_sdata;
  assign o_select = r_select;

endmodule

// File: tb/tb_adc_serial_arbiter.sv
// Self-checking bench for adc_serial_arbiter: a pin monitor decodes each
// frame (Select-low length, Sclk rises, captured word) and a small
// arbitration model predicts the owner of every grant.
module tb_adc_serial_arbiter;
  localparam int          SCLK_DIV   = 4;
  localparam int          GAP_CYCLES = 16;
  localparam logic [11:0] FRAME_HDR  = 12'h001;
  localparam int          FRAME_LOW  = (2 + 64) * SCLK_DIV;
`ifdef ADC_SER_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [3:0]  addr_v [3];
  logic [15:0] data_v [3];
  logic [2:0]  o_grant, o_done;
  logic        o_err, o_busy, o_sclk, o_sdata, o_select;

  int checks = 0;
  int failures = 0;
  int m_last = 2;

  adc_serial_arbiter #(.SCLK_DIV(SCLK_DIV), .GAP_CYCLES(GAP_CYCLES), .FRAME_HDR(FRAME_HDR)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_req(req),
    .i_addr0(addr_v[0]), .i_addr1(addr_v[1]), .i_addr2(addr_v[2]),
    .i_data0(data_v[0]), .i_data1(data_v[1]), .i_data2(data_v[2]),
    .o_grant(o_grant), .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
    .o_sclk(o_sclk), .o_sdata(o_sdata), .o_select(o_select)
  );

  always #5 clk = ~clk;

  // Pin monitor state
  int          sel_low_cnt = 0, rise_cnt = 0, high_run = 0;
  int          gap_viol = 0, onehot_viol = 0, glitch = 0;
  logic [31:0] cap_word = 32'h0;
  logic        prev_sel = 1'b1, prev_sclk = 1'b0, held_sdata = 1'b0;
  bit          have_frame = 1'b0;

  // Decode the serial pins once per cycle on the falling clock edge
  always @(negedge clk) begin
    if (rst) begin
      prev_sel   <= 1'b1;
      prev_sclk  <= 1'b0;
      have_frame <= 1'b0;
      high_run   <= 0;
    end else begin
      if (!o_select) begin
        if (prev_sel) begin
          if (have_frame && high_run < GAP_CYCLES) gap_viol <= gap_viol + 1;
          have_frame  <= 1'b1;
          sel_low_cnt <= 1;
          rise_cnt    <= 0;
          cap_word    <= 32'h0;
        end else begin
          sel_low_cnt <= sel_low_cnt + 1;
          if (o_sclk && !prev_sclk) begin
            rise_cnt   <= rise_cnt + 1;
            cap_word   <= {cap_word[30:0], o_sdata};
            held_sdata <= o_sdata;
          end else if (o_sclk && (o_sdata !== held_sdata)) begin
            glitch <= glitch + 1;
          end
        end
        high_run <= 0;
      end else begin
        high_run <= high_run + 1;
      end
      if ($countones(o_grant) > 1) onehot_viol <= onehot_viol + 1;
      prev_sel  <= o_select;
      prev_sclk <= o_sclk;
    end
  end

  // Reference arbitration: fixed priority, or rotate from the last owner
  function automatic int model_pick(input logic [2:0] r);
    int idx;
    for (int k = 0; k < 3; k++) begin
      idx = RR_MODE ? ((m_last + 1 + k) % 3) : k;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_grant !== 3'b000) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (o_done !== 3'b000 || o_err !== 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rises(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (rise_cnt >= n && !o_select) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!o_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({o_grant, o_done, o_err, o_busy, o_sclk, o_sdata, o_select} !== 11'b000_000_0_0_0_0_1) begin
      failures++;
      $display("FAIL reset_async: got %b expected %b",
               {o_grant, o_done, o_err, o_busy, o_sclk, o_sdata, o_select}, 11'b000_000_0_0_0_0_1);
    end
    enable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_last = 2;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_grant, o_busy, o_select} !== 5'b000_0_1) begin
      failures++;
      $display("FAIL reset_idle: got %b expected %b", {o_grant, o_busy, o_select}, 5'b000_0_1);
    end
  endtask

  task automatic test_single;
    bit ok;
    int n;
    @(negedge clk);
    addr_v[0] = 4'h3; data_v[0] = 16'hB2FF; req = 3'b001;
    @(negedge clk);
    checks++;
    if ({o_grant, o_busy, o_select, o_sdata} !== 6'b001_1_0_0) begin
      failures++;
      $display("FAIL single_latency: got %b expected %b", {o_grant, o_busy, o_select, o_sdata}, 6'b001_1_0_0);
    end
    m_last = 0;
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout: got no done expected done"); end
    checks++;
    if ({o_done, o_select, o_grant, o_err} !== 8'b001_1_000_0) begin
      failures++;
      $display("FAIL single_done: got %b expected %b", {o_done, o_select, o_grant, o_err}, 8'b001_1_000_0);
    end
    checks++;
    if (sel_low_cnt != FRAME_LOW) begin
      failures++; $display("FAIL single_sel_low: got %0d expected %0d", sel_low_cnt, FRAME_LOW);
    end
    checks++;
    if (rise_cnt != 32) begin
      failures++; $display("FAIL single_rises: got %0d expected %0d", rise_cnt, 32);
    end
    checks++;
    if (cap_word !== 32'h0013B2FF) begin
      failures++; $display("FAIL single_word: got %h expected %h", cap_word, 32'h0013B2FF);
    end
    req = 3'b000;
    n = 1;
    @(negedge clk);
    checks++;
    if (o_done !== 3'b000) begin
      failures++; $display("FAIL single_done_pulse: got %b expected %b", o_done, 3'b000);
    end
    for (int i = 0; i < 100 && o_busy; i++) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != GAP_CYCLES) begin
      failures++; $display("FAIL single_gap_busy: got %0d expected %0d", n, GAP_CYCLES);
    end
  endtask

  task automatic test_enable_idle;
    bit ok;
    enable = 1'b0;
    req = 3'b001;
    data_v[0] = 16'($urandom);
    repeat (6) @(negedge clk);
    checks++;
    if ({o_grant, o_select, o_busy} !== 5'b000_1_0) begin
      failures++; $display("FAIL en_low_idle: got %b expected %b", {o_grant, o_select, o_busy}, 5'b000_1_0);
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (o_grant !== 3'b001) begin
      failures++; $display("FAIL en_high_grant: got %b expected %b", o_grant, 3'b001);
    end
    m_last = 0;
    wait_done(ok);
    checks++;
    if (o_done !== 3'b001) begin
      failures++; $display("FAIL en_done: got %b expected %b", o_done, 3'b001);
    end
    req = 3'b000;
    wait_idle(ok);
  endtask

  task automatic test_priority_all;
    bit ok;
    int exp;
    logic [31:0] exp_word;
    for (int k = 0; k < 3; k++) begin
      addr_v[k] = 4'($urandom); data_v[k] = 16'($urandom);
    end
    req = 3'b111;
    for (int f = 0; f < 3; f++) begin
      wait_grant(ok);
      exp = model_pick(req);
      exp_word = {FRAME_HDR, addr_v[exp], data_v[exp]};
      checks++;
      if (!ok || o_grant !== 3'(1 << exp)) begin
        failures++; $display("FAIL prio_grant%0d: got %b expected %b", f, o_grant, 3'(1 << exp));
      end
      m_last = exp;
      wait_done(ok);
      checks++;
      if (o_done !== 3'(1 << exp) || cap_word !== exp_word) begin
        failures++;
        $display("FAIL prio_frame%0d: got done=%b word=%h expected done=%b word=%h",
                 f, o_done, cap_word, 3'(1 << exp), exp_word);
      end
      req[exp] = 1'b0;
    end
    wait_idle(ok);
  endtask

  task automatic test_starve;
    bit ok;
    int exp;
    req = 3'b101;
    for (int f = 0; f < 3; f++) begin
      wait_grant(ok);
      exp = model_pick(req);
      checks++;
      if (!ok || o_grant !== 3'(1 << exp)) begin
        failures++; $display("FAIL starve_grant%0d: got %b expected %b", f, o_grant, 3'(1 << exp));
      end
      m_last = exp;
      wait_done(ok);
      if (exp == 2) req[2] = 1'b0;
    end
    req = 3'b000;
    wait_idle(ok);
  endtask

  task automatic test_random;
    bit ok;
    int exp;
    logic [31:0] exp_word;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 3; k++) begin
        addr_v[k] = 4'($urandom); data_v[k] = 16'($urandom);
      end
      req = req | 3'($urandom_range(1, 7));
      wait_grant(ok);
      exp = model_pick(req);
      exp_word = {FRAME_HDR, addr_v[exp], data_v[exp]};
      checks++;
      if (!ok || o_grant !== 3'(1 << exp)) begin
        failures++; $display("FAIL rand_grant%0d: got %b expected %b", f, o_grant, 3'(1 << exp));
      end
      m_last = exp;
      // Owner withdraws and changes its inputs; the captured copy must be used.
      req[exp] = 1'b0;
      addr_v[exp] = ~addr_v[exp]; data_v[exp] = ~data_v[exp];
      wait_done(ok);
      checks++;
      if (o_done !== 3'(1 << exp) || cap_word !== exp_word || rise_cnt != 32) begin
        failures++;
        $display("FAIL rand_frame%0d: got done=%b word=%h rises=%0d expected done=%b word=%h rises=32",
                 f, o_done, cap_word, rise_cnt, 3'(1 << exp), exp_word);
      end
    end
    req = 3'b000;
    wait_idle(ok);
  endtask

  task automatic test_abort;
    bit ok;
    int n, done_seen;
    addr_v[1] = 4'($urandom); data_v[1] = 16'($urandom);
    req = 3'b010;
    wait_grant(ok);
    m_last = 1;
    wait_rises(10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_reach: got timeout expected 10 rises"); end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_select, o_sclk, o_sdata, o_err, o_grant, o_done, o_busy} !== 11'b1_0_0_1_000_000_1) begin
      failures++;
      $display("FAIL abort_outputs: got %b expected %b",
               {o_select, o_sclk, o_sdata, o_err, o_grant, o_done, o_busy}, 11'b1_0_0_1_000_000_1);
    end
    req = 3'b000;
    n = 1; done_seen = 0;
    @(negedge clk);
    checks++;
    if (o_err !== 1'b0) begin failures++; $display("FAIL abort_err_pulse: got %b expected %b", o_err, 1'b0); end
    for (int i = 0; i < 100 && o_busy; i++) begin
      if (o_done !== 3'b000) done_seen++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != GAP_CYCLES || done_seen != 0) begin
      failures++;
      $display("FAIL abort_gap: got busy=%0d dones=%0d expected busy=%0d dones=0", n, done_seen, GAP_CYCLES);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [31:0] exp_word;
    addr_v[2] = 4'($urandom); data_v[2] = 16'($urandom);
    exp_word = {FRAME_HDR, addr_v[2], data_v[2]};
    req = 3'b100;
    wait_grant(ok);
    wait_rises(5, ok);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_grant, o_done, o_err, o_busy, o_sclk, o_sdata, o_select} !== 11'b000_000_0_0_0_0_1) begin
      failures++;
      $display("FAIL reset_mid: got %b expected %b",
               {o_grant, o_done, o_err, o_busy, o_sclk, o_sdata, o_select}, 11'b000_000_0_0_0_0_1);
    end
    m_last = 2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_grant(ok);
    checks++;
    if (!ok || o_grant !== 3'b100) begin
      failures++; $display("FAIL reset_regrant: got %b expected %b", o_grant, 3'b100);
    end
    wait_done(ok);
    checks++;
    if (o_done !== 3'b100 || cap_word !== exp_word || rise_cnt != 32 || sel_low_cnt != FRAME_LOW) begin
      failures++;
      $display("FAIL reset_refrm: got done=%b word=%h rises=%0d low=%0d expected done=100 word=%h rises=32 low=%0d",
               o_done, cap_word, rise_cnt, sel_low_cnt, exp_word, FRAME_LOW);
    end
    req = 3'b000;
    wait_idle(ok);
  endtask

  task automatic test_invariants;
    checks++;
    if (gap_viol != 0) begin failures++; $display("FAIL gap_min: got %0d expected %0d", gap_viol, 0); end
    checks++;
    if (onehot_viol != 0) begin failures++; $display("FAIL grant_onehot: got %0d expected %0d", onehot_viol, 0); end
    checks++;
    if (glitch != 0) begin failures++; $display("FAIL sdata_stable: got %0d expected %0d", glitch, 0); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      addr_v[k] = 4'h0; data_v[k] = 16'h0000;
    end
    test_reset;
    test_single;
    test_enable_idle;
    test_priority_all;
    test_starve;
    test_random;
    test_abort;
    test_reset_mid;
    test_invariants;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
